// File: rtl/config_chain_loader.sv
// Host-side writer for the fabric configuration shift chain: takes bitstream words on a
// valid/ready stream, shifts them LSB-first onto the chain head, then pulses set to commit.
module config_chain_loader #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              cen,
  output logic              shift_out,
  output logic              set_out,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SET   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [LEN_W-1:0]    r_rem;
  logic [WORD_W-1:0]   r_shreg;
  logic [CNT_W-1:0]    r_wcnt;
  logic [CNT_W-1:0]    w_wcnt_load;

  // Stream handshake: a word transfers on any cycle where s_valid && s_ready are both high
  // at the rising edge; s_ready is high only in LOAD and s_data is taken whole into r_shreg.
  assign w_wcnt_load = (r_rem >= LEN_W'(WORD_W)) ? CNT_W'(WORD_W) : CNT_W'(r_rem);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (len != '0) ? S_LOAD : S_SET;
      S_LOAD:  if (s_valid) w_next = S_SHIFT;
      // Last bit of the stream wins over end-of-word so a final partial word goes straight to SET.
      S_SHIFT: begin
        if (r_rem == LEN_W'(1))      w_next = S_SET;
        else if (r_wcnt == CNT_W'(1)) w_next = S_LOAD;
      end
      S_SET:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem   <= '0;
      r_shreg <= '0;
      r_wcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) r_rem <= len;
        S_LOAD: begin
          if (s_valid) begin
            r_shreg <= s_data;
            r_wcnt  <= w_wcnt_load;
          end
        end
        S_SHIFT: begin
          r_shreg <= r_shreg >> 1;
          r_wcnt  <= r_wcnt - CNT_W'(1);
          r_rem   <= r_rem - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign s_ready   = (r_state == S_LOAD);
  assign cen       = (r_state == S_SHIFT);
  assign shift_out = (r_state == S_SHIFT) && r_shreg[0];
  assign set_out   = (r_state == S_SET);
  assign done      = (r_state == S_DONE);
  assign busy      = (r_state == S_LOAD) || (r_state == S_SHIFT) || (r_state == S_SET);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: scenario tasks drive a load, record the chain
// activity cycle by cycle relative to the start cycle, and compare against hand-derived values.
module tb_config_chain_loader;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_ready;
  logic [19:0] len;
  logic [31:0] s_data;
  logic        cen, shift_out, set_out, busy, done;
  logic [2:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] words[4];
  logic [0:0]  bits_q[$];
  logic [0:0]  exp_q[$];
  int cen_cnt, set_cnt, set_k, done_k, first_cen_k, last_cen_k;
  int ready_cnt, stall_cnt, busy_cnt, overlap_cnt;
  logic busy_at_done;
  bit timed_out;

  config_chain_loader #(.WORD_W(32), .LEN_W(20)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cen(cen), .shift_out(shift_out), .set_out(set_out),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Expected chain bits: word i/32, bit i%32, first bit first.
  task automatic build_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(words[i / 32][i % 32]);
  endtask

  function automatic int bit_errs();
    int e = 0;
    for (int i = 0; i < bits_q.size() && i < exp_q.size(); i++)
      if (bits_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  // k counts cycles after the start cycle; observation happens at the negedge of cycle k.
  task automatic run_xfer(input int n, input int nwords, input int gap,
                          input int restart_k, input int stop_k);
    int widx, waited, k;
    bits_q.delete();
    cen_cnt = 0; set_cnt = 0; set_k = -1; done_k = -1; first_cen_k = -1; last_cen_k = -1;
    ready_cnt = 0; stall_cnt = 0; busy_cnt = 0; overlap_cnt = 0; busy_at_done = 1'bx;
    timed_out = 0; widx = 0; waited = 0;
    @(negedge clk);
    start = 1'b1; len = n[19:0];
    s_valid = (nwords > 0); s_data = words[0];
    for (k = 1; k <= 400; k++) begin
      @(negedge clk);
      start = (k == restart_k);
      if (k == restart_k) len = 20'd3;
      if (cen) begin
        bits_q.push_back(shift_out); cen_cnt++;
        if (first_cen_k < 0) first_cen_k = k;
        last_cen_k = k;
      end
      if (s_ready) ready_cnt++;
      if (busy) busy_cnt++;
      if (set_out) begin set_cnt++; set_k = k; end
      if (cen && (s_ready || set_out || done)) overlap_cnt++;
      if (done) begin done_k = k; busy_at_done = busy; break; end
      if (k == stop_k) break;
      if (s_ready && widx < nwords) begin
        if (widx == 0 || waited >= gap) begin
          s_valid = 1'b1; s_data = words[widx]; widx++; waited = 0;
        end else begin
          s_valid = 1'b0; waited++; stall_cnt++;
        end
      end else begin
        s_valid = 1'b0;
      end
    end
    s_valid = 1'b0; start = 1'b0;
    if (k > 400) timed_out = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; len = '0; s_data = '0;
    repeat (2) @(negedge clk);
    tests_run++; if ({s_ready, cen, shift_out, set_out, busy, done} !== 6'b0) begin tests_failed++; $display("FAIL reset_outputs: got %b want 000000", {s_ready, cen, shift_out, set_out, busy, done}); end
    tests_run++; if (dbg_state !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word(input string tag);
    words[0] = 32'h0000_0016;
    run_xfer(5, 1, 0, -1, -1);
    build_exp(5);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL %s_timeout: got no done want done", tag); end
    tests_run++; if (bits_q.size() != 5 || bit_errs() != 0) begin tests_failed++; $display("FAIL %s_bits: got %0d bits %0d wrong want 5 bits 0,1,1,0,1", tag, bits_q.size(), bit_errs()); end
    tests_run++; if (first_cen_k !== 2 || last_cen_k !== 6) begin tests_failed++; $display("FAIL %s_cen_window: got %0d..%0d want 2..6", tag, first_cen_k, last_cen_k); end
    tests_run++; if (set_k !== 7 || set_cnt !== 1) begin tests_failed++; $display("FAIL %s_set: got cycle %0d count %0d want cycle 7 count 1", tag, set_k, set_cnt); end
    tests_run++; if (done_k !== 8) begin tests_failed++; $display("FAIL %s_done: got %0d want 8", tag, done_k); end
    tests_run++; if (busy_cnt !== 7 || busy_at_done !== 1'b0) begin tests_failed++; $display("FAIL %s_busy: got %0d cycles done-busy %b want 7 and 0", tag, busy_cnt, busy_at_done); end
  endtask

  task automatic test_two_words();
    logic [7:0] tail;
    words[0] = 32'hA5A5_A5A5; words[1] = 32'h0000_00F0;
    run_xfer(40, 2, 0, -1, -1);
    build_exp(40);
    tail = '0;
    for (int i = 0; i < 8 && 32 + i < bits_q.size(); i++) tail[i] = bits_q[32 + i];
    tests_run++; if (cen_cnt !== 40 || bit_errs() != 0) begin tests_failed++; $display("FAIL two_bits: got %0d cen %0d wrong want 40 cen 0 wrong", cen_cnt, bit_errs()); end
    tests_run++; if (tail !== 8'hF0) begin tests_failed++; $display("FAIL two_tail: got %h want f0", tail); end
    tests_run++; if (ready_cnt !== 2 || overlap_cnt !== 0) begin tests_failed++; $display("FAIL two_bubble: got ready %0d overlap %0d want 2 and 0", ready_cnt, overlap_cnt); end
    tests_run++; if (set_k !== 43 || set_cnt !== 1 || done_k !== 44) begin tests_failed++; $display("FAIL two_set_done: got set %0d x%0d done %0d want 43 x1 44", set_k, set_cnt, done_k); end
  endtask

  task automatic test_stalled_word();
    words[0] = 32'hA5A5_A5A5; words[1] = 32'h0000_00F0;
    run_xfer(40, 2, 10, -1, -1);
    build_exp(40);
    tests_run++; if (cen_cnt !== 40 || bit_errs() != 0) begin tests_failed++; $display("FAIL stall_bits: got %0d cen %0d wrong want 40 cen 0 wrong", cen_cnt, bit_errs()); end
    tests_run++; if (stall_cnt !== 10 || ready_cnt !== 12 || overlap_cnt !== 0) begin tests_failed++; $display("FAIL stall_hold: got stall %0d ready %0d overlap %0d want 10 12 0", stall_cnt, ready_cnt, overlap_cnt); end
    tests_run++; if (set_k !== 53 || done_k !== 54) begin tests_failed++; $display("FAIL stall_set_done: got %0d %0d want 53 54", set_k, done_k); end
  endtask

  task automatic test_zero_len();
    run_xfer(0, 0, 0, -1, -1);
    tests_run++; if (cen_cnt !== 0 || ready_cnt !== 0) begin tests_failed++; $display("FAIL zero_no_shift: got cen %0d ready %0d want 0 0", cen_cnt, ready_cnt); end
    tests_run++; if (set_k !== 1 || done_k !== 2 || set_cnt !== 1) begin tests_failed++; $display("FAIL zero_set_done: got %0d %0d x%0d want 1 2 x1", set_k, done_k, set_cnt); end
  endtask

  task automatic test_word_boundary();
    words[0] = 32'h8000_0001;
    run_xfer(32, 1, 0, -1, -1);
    build_exp(32);
    tests_run++; if (cen_cnt !== 32 || bit_errs() != 0 || ready_cnt !== 1) begin tests_failed++; $display("FAIL len32: got cen %0d wrong %0d ready %0d want 32 0 1", cen_cnt, bit_errs(), ready_cnt); end
    tests_run++; if (set_k !== 34 || done_k !== 35) begin tests_failed++; $display("FAIL len32_set_done: got %0d %0d want 34 35", set_k, done_k); end
    words[0] = 32'hFFFF_FFFF; words[1] = 32'hFFFF_FFFE;
    run_xfer(33, 2, 0, -1, -1);
    tests_run++; if (cen_cnt !== 33 || bits_q[32] !== 1'b0 || ready_cnt !== 2) begin tests_failed++; $display("FAIL len33: got cen %0d last %b ready %0d want 33 0 2", cen_cnt, bits_q[bits_q.size() - 1], ready_cnt); end
    tests_run++; if (set_k !== 36) begin tests_failed++; $display("FAIL len33_set: got %0d want 36", set_k); end
    words[0] = 32'hFFFF_FFFA;
    run_xfer(3, 1, 0, -1, -1);
    build_exp(3);
    tests_run++; if (cen_cnt !== 3 || bit_errs() != 0 || set_k !== 5) begin tests_failed++; $display("FAIL partial_discard: got cen %0d wrong %0d set %0d want 3 0 5", cen_cnt, bit_errs(), set_k); end
  endtask

  task automatic test_start_ignored();
    words[0] = 32'hA5A5_A5A5; words[1] = 32'h0000_00F0;
    run_xfer(40, 2, 0, 10, -1);
    build_exp(40);
    tests_run++; if (cen_cnt !== 40 || bit_errs() != 0) begin tests_failed++; $display("FAIL restart_bits: got %0d cen %0d wrong want 40 cen 0 wrong", cen_cnt, bit_errs()); end
    tests_run++; if (set_k !== 43 || set_cnt !== 1 || done_k !== 44) begin tests_failed++; $display("FAIL restart_set_done: got %0d x%0d %0d want 43 x1 44", set_k, set_cnt, done_k); end
  endtask

  task automatic test_mid_reset();
    int late_act;
    words[0] = 32'hA5A5_A5A5; words[1] = 32'h0000_00F0;
    run_xfer(40, 2, 0, -1, 11);
    tests_run++; if (cen_cnt !== 10 || set_cnt !== 0) begin tests_failed++; $display("FAIL midrst_pre: got cen %0d set %0d want 10 0", cen_cnt, set_cnt); end
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if ({s_ready, cen, shift_out, set_out, busy, done} !== 6'b0 || dbg_state !== 3'd0) begin tests_failed++; $display("FAIL midrst_outputs: got %b state %0d want 000000 state 0", {s_ready, cen, shift_out, set_out, busy, done}, dbg_state); end
    rst = 1'b0;
    late_act = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (set_out || cen || done || s_ready) late_act++;
    end
    tests_run++; if (late_act !== 0) begin tests_failed++; $display("FAIL midrst_quiet: got %0d active cycles want 0", late_act); end
    test_single_word("after_rst");
  endtask

  initial begin
    test_reset();
    test_single_word("single");
    test_two_words();
    test_stalled_word();
    test_zero_len();
    test_word_boundary();
    test_start_ignored();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
